// File: rtl/fir_capture_readout.sv
// Captures DEPTH samples after SKIP settling samples, then streams them out oldest first.
// Latency: first rd_valid two cycles after entering READOUT, then one beat per cycle.
// Backpressure: rd_ready low holds rd_data/rd_last; the prefetch stage stalls and no reads are lost.
module fir_capture_readout #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int SKIP       = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic                  arm,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done
);

    localparam int SKIP_W = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SKIP_W-1:0]     SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_CAPT,
        S_READ,
        S_DONE
    } state_t;

    state_t                state;
    logic [SKIP_W-1:0]     skip_cnt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  issue_done;
    logic                  q_vld;
    logic                  q_last;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  wr_en;
    logic                  rd_en;
    logic                  move;

    // ram_q is a holding stage: a new read is only issued when its content leaves
    assign wr_en = (state == S_CAPT) && sample_valid;
    assign move  = q_vld && (!rd_valid || rd_ready);
    assign rd_en = (state == S_READ) && !issue_done && (!q_vld || move);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= sample_in;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            skip_cnt   <= '0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            issue_done <= 1'b0;
            q_vld      <= 1'b0;
            q_last     <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            state      <= S_IDLE;
            skip_cnt   <= '0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            issue_done <= 1'b0;
            q_vld      <= 1'b0;
            q_last     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state    <= (SKIP == 0) ? S_CAPT : S_SKIP;
                        skip_cnt <= '0;
                        wr_addr  <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                S_SKIP: begin
                    if (sample_valid) begin
                        if (skip_cnt == SKIP_LAST) begin
                            state <= S_CAPT;
                        end else begin
                            skip_cnt <= skip_cnt + 1'b1;
                        end
                    end
                end
                S_CAPT: begin
                    if (sample_valid) begin
                        if (wr_addr == ADDR_LAST) begin
                            state      <= S_READ;
                            rd_addr    <= '0;
                            issue_done <= 1'b0;
                            q_vld      <= 1'b0;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (rd_en) begin
                        q_last     <= (rd_addr == ADDR_LAST);
                        issue_done <= (rd_addr == ADDR_LAST);
                        if (rd_addr != ADDR_LAST) begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                    if (rd_en) begin
                        q_vld <= 1'b1;
                    end else if (move) begin
                        q_vld <= 1'b0;
                    end
                    if (move) begin
                        rd_data  <= ram_q;
                        rd_valid <= 1'b1;
                        rd_last  <= q_last;
                    end else if (rd_valid && rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        if (rd_last) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_capture_readout.sv
// Bench: two capture units (SKIP=4 and SKIP=0) fed by a shared sample generator; expected
// beats are the valid samples after arm, minus the first SKIP, limited to DEPTH.
module tb_fir_capture_readout;

    localparam int DW = 32;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam logic signed [DW-1:0] CONST_NEG = -32768;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          arm [2];
    logic          abort [2];
    logic          rd_ready [2];
    logic [DW-1:0] rd_data [2];
    logic          rd_valid [2];
    logic          rd_last [2];
    logic          busy [2];
    logic          done [2];

    always #5 clk = ~clk;

    fir_capture_readout #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .SKIP(4)) dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .arm(arm[0]), .abort(abort[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .rd_ready(rd_ready[0]), .rd_last(rd_last[0]), .busy(busy[0]), .done(done[0])
    );

    fir_capture_readout #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .SKIP(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .arm(arm[1]), .abort(abort[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .rd_ready(rd_ready[1]), .rd_last(rd_last[1]), .busy(busy[1]), .done(done[1])
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // sample generator: ramp advances once per valid sample, restarts whenever switched off
    bit          gen_on = 1'b0;
    bit          gen_toggle = 1'b0;
    bit          gen_const = 1'b0;
    logic [31:0] gen_base = '0;
    logic [31:0] ramp = '0;

    always @(posedge clk) begin
        #1;
        if (!gen_on) begin
            sample_valid = 1'b0;
            sample_in    = '0;
            ramp         = '0;
        end else begin
            sample_valid = gen_toggle ? !sample_valid : 1'b1;
            sample_in    = gen_const ? CONST_NEG : gen_base + ramp;
            if (sample_valid) ramp = ramp + 1;
        end
    end

    // reference model and scoreboard monitor, evaluated mid-cycle for the coming edge
    logic [31:0] exp_q [2][$];
    bit          model_busy [2];
    bit          collecting [2];
    bit          stall_pend [2];
    int          vcount [2];
    int          beat_idx [2];
    logic [31:0] held_data [2];
    logic        held_last [2];
    logic [31:0] first_beat [2];
    logic [31:0] last_beat [2];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int sk;
            logic [31:0] e;
            sk = (g == 0) ? 4 : 0;
            if (!rst_n) begin
                exp_q[g].delete();
                model_busy[g] = 1'b0;
                collecting[g] = 1'b0;
                stall_pend[g] = 1'b0;
                vcount[g]     = 0;
            end else begin
                if (abort[g]) begin
                    exp_q[g].delete();
                    model_busy[g] = 1'b0;
                    collecting[g] = 1'b0;
                end else if (arm[g] && !model_busy[g]) begin
                    model_busy[g] = 1'b1;
                    collecting[g] = 1'b1;
                    vcount[g]     = 0;
                    beat_idx[g]   = 0;
                end else if (collecting[g] && sample_valid) begin
                    vcount[g]++;
                    if (vcount[g] > sk) exp_q[g].push_back(sample_in);
                    if (vcount[g] == sk + D) collecting[g] = 1'b0;
                end

                if (stall_pend[g]) begin
                    chk("stall_valid", 32'(rd_valid[g]), 32'd1);
                    chk("stall_data", rd_data[g], held_data[g]);
                    chk("stall_last", 32'(rd_last[g]), 32'(held_last[g]));
                end
                if (rd_valid[g] && rd_ready[g] && !abort[g]) begin
                    if (exp_q[g].size() == 0) begin
                        n_chk++;
                        n_bad++;
                        $display("FAIL extra_beat inst=%0d: got %h, want no beat", g, rd_data[g]);
                    end else begin
                        e = exp_q[g].pop_front();
                        chk("beat_data", rd_data[g], e);
                        chk("beat_last", 32'(rd_last[g]), 32'(beat_idx[g] == D - 1));
                        if (beat_idx[g] == 0) first_beat[g] = rd_data[g];
                        last_beat[g] = rd_data[g];
                        beat_idx[g]++;
                        if (beat_idx[g] == D) model_busy[g] = 1'b0;
                    end
                end
                stall_pend[g] = rd_valid[g] && !rd_ready[g] && !abort[g];
                held_data[g]  = rd_data[g];
                held_last[g]  = rd_last[g];
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_arm(input int g);
        arm[g] = 1'b1;
        tick();
        arm[g] = 1'b0;
    endtask

    task automatic check_zero(input int g);
        chk("zero_rd_data", rd_data[g], 32'd0);
        chk("zero_rd_valid", 32'(rd_valid[g]), 32'd0);
        chk("zero_rd_last", 32'(rd_last[g]), 32'd0);
        chk("zero_busy", 32'(busy[g]), 32'd0);
        chk("zero_done", 32'(done[g]), 32'd0);
    endtask

    task automatic wait_valid(input int g);
        int n;
        n = 0;
        while (!rd_valid[g] && n < 200) begin
            tick();
            n++;
        end
        chk("reach_readout", 32'(rd_valid[g]), 32'd1);
    endtask

    task automatic wait_done(input int g);
        int n;
        n = 0;
        while (!done[g] && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic end_checks(input int g, input logic [31:0] f, input logic [31:0] l);
        chk("done_flag", 32'(done[g]), 32'd1);
        chk("busy_after", 32'(busy[g]), 32'd0);
        chk("valid_after", 32'(rd_valid[g]), 32'd0);
        chk("beat_count", beat_idx[g], D);
        chk("first_beat", first_beat[g], f);
        chk("last_beat", last_beat[g], l);
        chk("beats_missing", exp_q[g].size(), 32'd0);
    endtask

    initial begin
        int nv;
        int n;
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            arm[g]      = 1'b0;
            abort[g]    = 1'b0;
            rd_ready[g] = 1'b0;
            beat_idx[g] = 0;
        end
        repeat (3) tick();
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;
        tick();

        // reset in the middle of a stalled readout
        gen_on = 1'b1;
        pulse_arm(0);
        wait_valid(0);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check_zero(0);
        gen_on = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy[0]), 32'd0);
        chk("idle_valid", 32'(rd_valid[0]), 32'd0);

        // ramp, continuous valid, rd_ready high: back-to-back beats 4..19
        rd_ready[0] = 1'b1;
        gen_on = 1'b1;
        pulse_arm(0);
        wait_valid(0);
        nv = 0;
        for (int i = 0; i < D; i++) begin
            if (rd_valid[0]) nv++;
            tick();
        end
        chk("b2b_valid_cycles", nv, D);
        end_checks(0, 32'd4, 32'd19);
        gen_on = 1'b0;
        tick();

        // toggling sample_valid, random backpressure
        gen_on = 1'b1;
        gen_toggle = 1'b1;
        pulse_arm(0);
        n = 0;
        while (!done[0] && n < 600) begin
            rd_ready[0] = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        end_checks(0, 32'd4, 32'd19);
        rd_ready[0] = 1'b1;
        gen_on = 1'b0;
        gen_toggle = 1'b0;
        tick();

        // SKIP=0 unit, negative constant keeps its sign bits
        gen_const = 1'b1;
        gen_on = 1'b1;
        rd_ready[1] = 1'b1;
        pulse_arm(1);
        wait_done(1);
        end_checks(1, 32'hFFFF8000, 32'hFFFF8000);
        gen_on = 1'b0;
        gen_const = 1'b0;
        tick();

        // arm during capture is ignored; abort at beat 5; then a full restart
        rd_ready[0] = 1'b0;
        gen_on = 1'b1;
        pulse_arm(0);
        repeat (7) tick();
        chk("busy_capture", 32'(busy[0]), 32'd1);
        pulse_arm(0);
        wait_valid(0);
        rd_ready[0] = 1'b1;
        n = 0;
        while (beat_idx[0] < 5 && n < 100) begin
            tick();
            n++;
        end
        chk("beats_before_abort", beat_idx[0], 32'd5);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("abort_valid", 32'(rd_valid[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_done", 32'(done[0]), 32'd0);
        chk("abort_first", first_beat[0], 32'd4);
        gen_on = 1'b0;
        tick();
        gen_on = 1'b1;
        pulse_arm(0);
        wait_done(0);
        end_checks(0, 32'd4, 32'd19);

        // re-arm from DONE with fresh data
        gen_on = 1'b0;
        tick();
        gen_base = 32'd1000;
        gen_on = 1'b1;
        pulse_arm(0);
        wait_done(0);
        end_checks(0, 32'd1004, 32'd1019);
        gen_on = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
